// File: rtl/shared_reg_arbiter.sv
// Shares one register among N requesters (round-robin, or lowest-index-first with ARB_FIXED_PRIO_EN); gnt 1 cycle after req, q/q_vld 1 cycle after each write.
// No backpressure: a grant ends after HOLD writes or when the owner drops req, and one idle cycle separates consecutive grants.
module shared_reg_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   din,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic [WIDTH-1:0]     q,
  output logic                 q_vld
);

  localparam int OW = $clog2(N);
  localparam int CW = $clog2(HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [N-1:0]     gnt_n;
  logic [OW-1:0]    owner_n;
  logic [WIDTH-1:0] q_n;
  logic             q_vld_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [OW-1:0]    sel;
  logic             found;
  logic             rel;
`ifndef ARB_FIXED_PRIO_EN
  logic [OW-1:0]    ptr, ptr_n;
  logic [OW-1:0]    nxt;

  assign nxt = (int'(owner) == N - 1) ? '0 : owner + 1'b1;
`endif

  // First requester at or after the search start, wrapping past N-1.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      if (!found && req[k]) begin
        found = 1'b1;
        sel   = OW'(k);
      end
`else
      if (!found && req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        sel   = OW'((int'(ptr) + k) % N);
      end
`endif
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    q_n     = q;
    q_vld_n = 1'b0;
    cnt_n   = cnt;
    rel     = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    ptr_n   = ptr;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          gnt_n      = '0;
          gnt_n[sel] = 1'b1;
          owner_n    = sel;
          cnt_n      = '0;
          state_n    = GRANT;
        end
      end
      GRANT: begin
        if (req[owner]) begin
          q_n     = din[int'(owner)*WIDTH +: WIDTH];
          q_vld_n = 1'b1;
          cnt_n   = cnt + 1'b1;
          if (int'(cnt) + 1 >= HOLD) rel = 1'b1;
        end else begin
          rel = 1'b1;
        end
        if (rel) begin
          gnt_n   = '0;
          state_n = IDLE;
`ifndef ARB_FIXED_PRIO_EN
          ptr_n   = nxt;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      q     <= '0;
      q_vld <= 1'b0;
      cnt   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      ptr   <= '0;
`endif
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      owner <= owner_n;
      q     <= q_n;
      q_vld <= q_vld_n;
      cnt   <= cnt_n;
`ifndef ARB_FIXED_PRIO_EN
      ptr   <= ptr_n;
`endif
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboarded random + directed bench for shared_reg_arbiter (N=4, WIDTH=8, HOLD=2).
module tb_shared_reg_arbiter;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int HOLD = 2;

  logic           clk = 1'b0;
  logic           res = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] din = '0;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic [W-1:0]   q;
  logic           q_vld;

  shared_reg_arbiter #(.N(N), .WIDTH(W), .HOLD(HOLD)) dut (
    .clk(clk), .res(res), .req(req), .din(din),
    .gnt(gnt), .owner(owner), .q(q), .q_vld(q_vld)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    int           owner;
    logic [W-1:0] q;
    logic         qv;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a grant is "a run of up to HOLD writes by one requester".
  bit           m_busy   = 1'b0;
  int           m_cur    = 0;
  int           m_writes = 0;
  int           m_ptr    = 0;
  logic [W-1:0] m_q      = '0;
  logic         m_qv     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    int start;
    start = p;
`ifdef ARB_FIXED_PRIO_EN
    start = 0;
`endif
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    exp_t e;
    int   s;
    if (res) begin
      m_busy = 1'b0; m_cur = 0; m_writes = 0; m_ptr = 0; m_q = '0; m_qv = 1'b0;
    end else if (!m_busy) begin
      m_qv = 1'b0;
      s = pick(req, m_ptr);
      if (s >= 0) begin
        m_busy = 1'b1; m_cur = s; m_writes = 0;
      end
    end else begin
      if (req[m_cur]) begin
        m_q = din[m_cur*W +: W];
        m_qv = 1'b1;
        m_writes++;
      end else begin
        m_qv = 1'b0;
      end
      if (!req[m_cur] || m_writes == HOLD) begin
        m_busy = 1'b0;
        m_ptr  = (m_cur + 1) % N;
      end
    end
    e.gnt = '0;
    if (m_busy) e.gnt[m_cur] = 1'b1;
    e.owner = m_cur;
    e.q     = m_q;
    e.qv    = m_qv;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] d);
    @(posedge clk);
    #1;
    res = r;
    req = rq;
    din = d;
    model_step();
  endtask

  // Monitor: compares DUT outputs each cycle against the queued expectation.
  initial begin
    exp_t         e;
    logic [N-1:0] prev_g;
    prev_g = '0;
    @(posedge clk);
    forever begin
      @(posedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("gnt", 32'(gnt), 32'(e.gnt));
        check("owner", 32'(owner), e.owner);
        check("q", 32'(q), 32'(e.q));
        check("q_vld", 32'(q_vld), 32'(e.qv));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        if (gnt != '0 && prev_g == '0) gnt_log.push_back(int'(owner));
        prev_g = gnt;
      end
    end
  end

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   rq;
    int             exp_order[5];

    // Reset with everything asserted
    cyc(1'b1, 4'b1111, {4{8'hFF}});
    cyc(1'b1, 4'b1111, {4{8'hFF}});
    cyc(1'b0, 4'b0000, {4{8'hFF}});
    cyc(1'b0, 4'b0000, '0);

    // Single requester holding its request
    d = '0;
    d[2*W +: W] = 8'hA5;
    repeat (5) cyc(1'b0, 4'b0100, d);
    repeat (2) cyc(1'b0, 4'b0000, d);

    // All requesting: rotation order from a fresh reset
    d = {8'h13, 8'h12, 8'h11, 8'h10};
    cyc(1'b1, 4'b0000, d);
    gnt_log.delete();
    repeat (16) cyc(1'b0, 4'b1111, d);
    repeat (2) cyc(1'b0, 4'b0000, d);
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    check("grant_count", 32'(gnt_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < gnt_log.size()) check("grant_order", gnt_log[i], exp_order[i]);

    // Early release, then pointer moves past requester 1
    d = {8'h44, 8'h33, 8'h22, 8'h11};
    cyc(1'b0, 4'b0010, d);
    cyc(1'b0, 4'b0010, d);
    cyc(1'b0, 4'b0000, d);
    repeat (4) cyc(1'b0, 4'b0110, d);
    repeat (2) cyc(1'b0, 4'b0000, d);

    // Reset during first grant cycle of requester 3
    d = {8'hC3, 8'h00, 8'h00, 8'h00};
    cyc(1'b0, 4'b1000, d);
    cyc(1'b1, 4'b1000, d);
    repeat (4) cyc(1'b0, 4'b1000, d);
    repeat (2) cyc(1'b0, 4'b0000, d);

    // Two competing requesters
    d = {$urandom};
    repeat (12) cyc(1'b0, 4'b1010, d);

    // Random traffic with sticky requests and occasional reset
    rq = '0;
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      d = {$urandom};
      cyc($urandom_range(0, 59) == 0, rq, d);
    end
    repeat (2) cyc(1'b0, 4'b0000, '0);

    @(posedge clk);
    #5;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
